// File: rtl/bus_ctrl.sv
// bus_ctrl: i8080 bus-cycle controller. Latches the sync status word, decodes memory/IO/INTA
// strobes, inserts wait states through ready, and arbitrates edge-triggered interrupt requests.
module bus_ctrl #(
  parameter int unsigned XLEN        = 8,
  parameter int unsigned NUM_IRQ     = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sync,
  input  logic               dbin,
  input  logic               write_n,
  input  logic [XLEN-1:0]    data_in,
  input  logic               inte,
  input  logic [NUM_IRQ-1:0] irq,
  output logic               ready,
  output logic               int_req,
  output logic               mem_enable,
  output logic               io_rd,
  output logic               io_wr,
  output logic               inta_drive,
  output logic [XLEN-1:0]    inta_data,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               halted
);

  // Status word bit positions.
  localparam int unsigned BitInta = 0;
  localparam int unsigned BitHlta = 3;
  localparam int unsigned BitOut  = 4;
  localparam int unsigned BitM1   = 5;
  localparam int unsigned BitInp  = 6;

  typedef enum logic [1:0] {StIdle, StWait, StActive} state_e;

  state_e             state_q;
  logic [3:0]         cnt_q;
  logic [XLEN-1:0]    status_q;
  logic               strb_q;
  logic               strb;
  logic               cyc_active;

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] pending_d;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr;
  logic               dbin_q;
  logic [2:0]         sel_idx_q;
  logic               sel_valid_q;
  logic [2:0]         win_idx;
  logic               win_valid;
  logic               ack_fire;
  logic               inta_sync;
  logic               unused_status;

  // WO_n, STACK and MEMR are latched with the word but need no decode here.
  assign unused_status = ^{status_q[7], status_q[2], status_q[1]};

  assign strb       = dbin | ~write_n;
  assign cyc_active = (state_q != StIdle);

  assign mem_enable = cyc_active & ~status_q[BitInta] & ~status_q[BitInp] & ~status_q[BitOut];
  assign io_rd      = cyc_active & status_q[BitInp] & dbin;
  assign io_wr      = cyc_active & status_q[BitOut] & ~write_n;
  assign inta_drive = cyc_active & status_q[BitInta] & dbin;
  assign halted     = status_q[BitHlta];

  // Cycle FSM: status latch, wait-state counter and ready generation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      status_q <= '0;
      ready    <= 1'b1;
      strb_q   <= 1'b0;
    end else begin
      strb_q <= strb;
      if (sync) begin
        status_q <= data_in;
        if (WAIT_STATES == 0) begin
          state_q <= StActive;
          cnt_q   <= '0;
          ready   <= 1'b1;
        end else begin
          state_q <= StWait;
          cnt_q   <= 4'(WAIT_STATES);
          ready   <= 1'b0;
        end
      end else begin
        unique case (state_q)
          StWait: begin
            if (cnt_q <= 4'd1) begin
              state_q <= StActive;
              cnt_q   <= '0;
              ready   <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
          // Leave once the data strobe has dropped.
          StActive: if (strb_q && !strb) state_q <= StIdle;
          default: ;
        endcase
      end
    end
  end

  assign rise      = irq & ~irq_q;
  assign inta_sync = sync & data_in[BitInta] & data_in[BitM1];
  // Acknowledge on the falling edge of dbin in a real (non-spurious) INTA M1 cycle.
  assign ack_fire  = cyc_active & status_q[BitInta] & status_q[BitM1] & sel_valid_q &
                     dbin_q & ~dbin;

  // Lowest pending index wins; clear vector for the acknowledged requester.
  always_comb begin
    win_idx   = '0;
    win_valid = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        win_idx   = 3'(i);
        win_valid = 1'b1;
      end
    end
    for (int i = 0; i < NUM_IRQ; i++) begin
      clr[i] = ack_fire && (sel_idx_q == 3'(i));
    end
    // A new edge on the same cycle as its clear keeps the bit pending.
    pending_d = (pending_q & ~clr) | rise;
  end

  // Interrupt state: edge detect, pending bits, frozen winner, opcode and ack pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Lines already high when reset releases must not count as a fresh edge.
      irq_q       <= '1;
      dbin_q      <= 1'b0;
      pending_q   <= '0;
      sel_idx_q   <= '0;
      sel_valid_q <= 1'b0;
      inta_data   <= XLEN'(8'hC7);
      irq_ack     <= '0;
      int_req     <= 1'b0;
    end else begin
      irq_q     <= irq;
      dbin_q    <= dbin;
      pending_q <= pending_d;
      irq_ack   <= clr;
      int_req   <= inte & (|pending_q);
      if (inta_sync) begin
        sel_idx_q   <= win_idx;
        sel_valid_q <= win_valid;
        inta_data   <= win_valid ? (XLEN'(8'hC7) | XLEN'({win_idx, 3'b000})) : '1;
      end
    end
  end

endmodule

// File: tb/tb_bus_ctrl.sv
// Self-checking bench for bus_ctrl with a queue-free behavioural interrupt model.
module tb_bus_ctrl;

  localparam int unsigned Ws = 2;

  logic       clk = 1'b0;
  logic       rst_n, sync, dbin, write_n, inte;
  logic [7:0] data_in, irq;
  logic       ready, int_req, mem_enable, io_rd, io_wr, inta_drive, halted;
  logic [7:0] inta_data, irq_ack;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: pending set of requesters.
  logic [7:0] pend;

  // Observations from the INTA driver.
  logic [7:0] obs_op0, obs_op3, obs_ack_early, obs_ack, obs_ack_after;
  logic       obs_drive, obs_drive_off, obs_int_req;
  logic       obs_ir1, obs_ir2;

  bus_ctrl #(.XLEN(8), .NUM_IRQ(8), .WAIT_STATES(Ws)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sync       (sync),
    .dbin       (dbin),
    .write_n    (write_n),
    .data_in    (data_in),
    .inte       (inte),
    .irq        (irq),
    .ready      (ready),
    .int_req    (int_req),
    .mem_enable (mem_enable),
    .io_rd      (io_rd),
    .io_wr      (io_wr),
    .inta_drive (inta_drive),
    .inta_data  (inta_data),
    .irq_ack    (irq_ack),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_opcode(input logic [7:0] p);
    for (int i = 0; i < 8; i++) if (p[i]) return 8'hC7 | 8'(i * 8);
    return 8'hFF;
  endfunction

  function automatic logic [7:0] exp_ackmask(input logic [7:0] p);
    for (int i = 0; i < 8; i++) if (p[i]) return 8'(1 << i);
    return 8'h00;
  endfunction

  // Drive a fresh rising edge on the lines in m; record int_req one and two cycles later.
  task automatic raise_irq(input logic [7:0] m);
    irq = irq & ~m;
    tick();
    irq = irq | m;
    tick();
    obs_ir1 = int_req;
    tick();
    obs_ir2 = int_req;
  endtask

  // One INTA M1 bus cycle; late lines rise after sync, reedge lines re-edge as dbin falls.
  task automatic inta_cycle(input logic [7:0] late, input logic [7:0] reedge);
    sync = 1'b1; data_in = 8'h23;
    tick();
    sync = 1'b0;
    obs_op0 = inta_data;
    dbin = 1'b1;
    irq  = irq | late;
    tick();
    obs_drive     = inta_drive;
    obs_ack_early = irq_ack;
    tick();
    obs_drive     = obs_drive & inta_drive;
    obs_ack_early = obs_ack_early | irq_ack;
    irq = irq & ~reedge;
    tick();
    obs_drive     = obs_drive & inta_drive;
    obs_ack_early = obs_ack_early | irq_ack;
    obs_op3       = inta_data;
    dbin = 1'b0;
    irq  = irq | reedge;
    tick();
    obs_ack       = irq_ack;
    obs_drive_off = inta_drive;
    tick();
    obs_ack_after = irq_ack;
    obs_int_req   = int_req;
  endtask

  task automatic test_reset();
    logic [22:0] rv;
    logic        seen;
    rst_n = 1'b0; sync = 1'b0; dbin = 1'b0; write_n = 1'b1; inte = 1'b1;
    data_in = 8'h00; irq = 8'h00; pend = 8'h00;
    tick(); tick();
    rv = {ready, int_req, mem_enable, io_rd, io_wr, inta_drive, halted, irq_ack, inta_data};
    n_checks++;
    if (rv !== {7'b1000000, 8'h00, 8'hC7}) begin
      n_fail++; $display("FAIL reset_values: got %h expected %h", rv, {7'b1000000, 8'h00, 8'hC7});
    end
    @(negedge clk); rst_n = 1'b1;
    tick(); tick();
    irq = 8'h01;
    tick(); tick(); tick();
    n_checks++;
    if (int_req !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre_pend: int_req got %b expected 1", int_req);
    end
    sync = 1'b1; data_in = 8'h23;
    tick();
    sync = 1'b0; dbin = 1'b1;
    tick();
    n_checks++;
    if (inta_drive !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre_drive: inta_drive got %b expected 1", inta_drive);
    end
    #2 rst_n = 1'b0;
    #1;
    rv = {ready, int_req, mem_enable, io_rd, io_wr, inta_drive, halted, irq_ack, inta_data};
    n_checks++;
    if (rv !== {7'b1000000, 8'h00, 8'hC7}) begin
      n_fail++; $display("FAIL reset_midcycle: got %h expected %h", rv, {7'b1000000, 8'h00, 8'hC7});
    end
    dbin = 1'b0;
    tick();
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      seen = seen | int_req | (|irq_ack);
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_repend: int_req/irq_ack activity got %b expected 0", seen);
    end
  endtask

  task automatic test_mem_read();
    int low;
    sync = 1'b1; data_in = 8'hA2;
    tick();
    sync = 1'b0; dbin = 1'b1;
    n_checks++;
    if ({mem_enable, io_rd} !== 2'b10) begin
      n_fail++; $display("FAIL memrd_decode: {mem_enable,io_rd} got %b expected 10", {mem_enable, io_rd});
    end
    low = 0;
    for (int k = 0; k < 20 && ready === 1'b0; k++) begin
      low++;
      tick();
    end
    n_checks++;
    if (low != Ws) begin
      n_fail++; $display("FAIL memrd_wait: ready low cycles got %0d expected %0d", low, Ws);
    end
    n_checks++;
    if ({ready, mem_enable, io_rd} !== 3'b110) begin
      n_fail++; $display("FAIL memrd_active: {ready,mem_enable,io_rd} got %b expected 110",
                         {ready, mem_enable, io_rd});
    end
    dbin = 1'b0;
    tick(); tick();
  endtask

  task automatic test_io_read();
    sync = 1'b1; data_in = 8'h42;
    tick();
    sync = 1'b0; dbin = 1'b1;
    tick();
    n_checks++;
    if ({mem_enable, io_rd, io_wr} !== 3'b010) begin
      n_fail++; $display("FAIL iord_decode: {mem_enable,io_rd,io_wr} got %b expected 010",
                         {mem_enable, io_rd, io_wr});
    end
    dbin = 1'b0;
    tick(); tick();
  endtask

  task automatic test_out_cycle();
    int n, cnt;
    n = int'($urandom_range(1, 3));
    sync = 1'b1; data_in = 8'h10;
    tick();
    sync = 1'b0;
    n_checks++;
    if ({mem_enable, io_wr} !== 2'b00) begin
      n_fail++; $display("FAIL out_decode: {mem_enable,io_wr} got %b expected 00", {mem_enable, io_wr});
    end
    tick(); tick();
    cnt = 0;
    for (int k = 0; k < n + 3; k++) begin
      write_n = (k < n) ? 1'b0 : 1'b1;
      tick();
      if (io_wr === 1'b1) cnt++;
    end
    n_checks++;
    if (cnt != n) begin
      n_fail++; $display("FAIL out_iowr_len: io_wr cycles got %0d expected %0d", cnt, n);
    end
  endtask

  task automatic test_halted();
    sync = 1'b1; data_in = 8'h8A;
    tick();
    sync = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if (halted !== 1'b1) begin
      n_fail++; $display("FAIL halted_set: got %b expected 1", halted);
    end
    sync = 1'b1; data_in = 8'hA2;
    tick();
    sync = 1'b0;
    n_checks++;
    if (halted !== 1'b0) begin
      n_fail++; $display("FAIL halted_clear: got %b expected 0", halted);
    end
    tick(); tick(); tick();
  endtask

  task automatic test_two_irqs();
    irq = 8'h00;
    raise_irq(8'h24);
    pend = pend | 8'h24;
    n_checks++;
    if ({obs_ir1, obs_ir2} !== 2'b01) begin
      n_fail++; $display("FAIL irq_latency: int_req at +1,+2 got %b expected 01", {obs_ir1, obs_ir2});
    end
    for (int r = 0; r < 2; r++) begin
      logic [7:0] eo, ea;
      eo = exp_opcode(pend);
      ea = exp_ackmask(pend);
      pend = pend & ~ea;
      inta_cycle(8'h00, 8'h00);
      n_checks++;
      if ({obs_op0, obs_op3} !== {eo, eo}) begin
        n_fail++; $display("FAIL two_opcode: got %h/%h expected %h", obs_op0, obs_op3, eo);
      end
      n_checks++;
      if ({obs_drive, obs_drive_off} !== 2'b10) begin
        n_fail++; $display("FAIL two_drive: {during,after} got %b expected 10",
                           {obs_drive, obs_drive_off});
      end
      n_checks++;
      if ({obs_ack_early, obs_ack, obs_ack_after} !== {8'h00, ea, 8'h00}) begin
        n_fail++; $display("FAIL two_ack: got %h,%h,%h expected 00,%h,00",
                           obs_ack_early, obs_ack, obs_ack_after, ea);
      end
      n_checks++;
      if (obs_int_req !== (pend != 8'h00)) begin
        n_fail++; $display("FAIL two_int_req: got %b expected %b", obs_int_req, pend != 8'h00);
      end
    end
  endtask

  task automatic test_late_arrival();
    logic [7:0] eo, ea;
    irq = 8'h00;
    raise_irq(8'h08);
    pend = pend | 8'h08;
    eo = exp_opcode(pend);
    ea = exp_ackmask(pend);
    pend = (pend & ~ea) | 8'h01;
    inta_cycle(8'h01, 8'h00);
    n_checks++;
    if ({obs_op0, obs_op3, obs_ack} !== {eo, eo, ea}) begin
      n_fail++; $display("FAIL late_frozen: op %h/%h ack %h expected op %h ack %h",
                         obs_op0, obs_op3, obs_ack, eo, ea);
    end
    n_checks++;
    if (obs_int_req !== 1'b1) begin
      n_fail++; $display("FAIL late_pending: int_req got %b expected 1", obs_int_req);
    end
    eo = exp_opcode(pend);
    ea = exp_ackmask(pend);
    pend = pend & ~ea;
    inta_cycle(8'h00, 8'h00);
    n_checks++;
    if ({obs_op3, obs_ack, obs_int_req} !== {eo, ea, pend != 8'h00}) begin
      n_fail++; $display("FAIL late_next: op %h ack %h int_req %b expected %h %h %b",
                         obs_op3, obs_ack, obs_int_req, eo, ea, pend != 8'h00);
    end
  endtask

  task automatic test_spurious_and_reedge();
    logic [7:0] eo, ea;
    irq = 8'h00;
    eo = exp_opcode(pend);
    ea = exp_ackmask(pend);
    inta_cycle(8'h00, 8'h00);
    n_checks++;
    if ({obs_op3, obs_ack_early, obs_ack, obs_ack_after, obs_int_req} !== {eo, 8'h00, ea, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL spurious: op %h ack %h int_req %b expected %h %h 0",
                         obs_op3, obs_ack, obs_int_req, eo, ea);
    end
    raise_irq(8'h02);
    pend = pend | 8'h02;
    eo = exp_opcode(pend);
    ea = exp_ackmask(pend);
    pend = (pend & ~ea) | 8'h02;
    inta_cycle(8'h00, 8'h02);
    n_checks++;
    if ({obs_op3, obs_ack, obs_int_req} !== {eo, ea, pend != 8'h00}) begin
      n_fail++; $display("FAIL reedge_setwins: op %h ack %h int_req %b expected %h %h %b",
                         obs_op3, obs_ack, obs_int_req, eo, ea, pend != 8'h00);
    end
    eo = exp_opcode(pend);
    ea = exp_ackmask(pend);
    pend = pend & ~ea;
    inta_cycle(8'h00, 8'h00);
    n_checks++;
    if ({obs_op3, obs_ack, obs_int_req} !== {eo, ea, pend != 8'h00}) begin
      n_fail++; $display("FAIL reedge_drain: op %h ack %h int_req %b expected %h %h %b",
                         obs_op3, obs_ack, obs_int_req, eo, ea, pend != 8'h00);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 16; r++) begin
      logic [7:0] m, prev;
      int nint;
      inte = 1'($urandom_range(0, 3) != 0);
      m    = 8'($urandom_range(1, 255));
      prev = pend;
      raise_irq(m);
      pend = pend | m;
      n_checks++;
      if ({obs_ir1, obs_ir2} !== {inte && (prev != 8'h00), inte}) begin
        n_fail++; $display("FAIL rand_int_req[%0d]: got %b expected %b", r,
                           {obs_ir1, obs_ir2}, {inte && (prev != 8'h00), inte});
      end
      nint = int'($urandom_range(1, 3));
      for (int j = 0; j < nint; j++) begin
        logic [7:0] eo, ea;
        eo = exp_opcode(pend);
        ea = exp_ackmask(pend);
        pend = pend & ~ea;
        inta_cycle(8'h00, 8'h00);
        n_checks++;
        if ({obs_op0, obs_op3, obs_ack_early, obs_ack, obs_ack_after, obs_int_req} !==
            {eo, eo, 8'h00, ea, 8'h00, inte && (pend != 8'h00)}) begin
          n_fail++; $display("FAIL rand_inta[%0d.%0d]: op %h/%h ack %h/%h/%h int_req %b expected op %h ack %h int_req %b",
                             r, j, obs_op0, obs_op3, obs_ack_early, obs_ack, obs_ack_after,
                             obs_int_req, eo, ea, inte && (pend != 8'h00));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mem_read();
    test_io_read();
    test_out_cycle();
    test_halted();
    test_two_irqs();
    test_late_arrival();
    test_spurious_and_reedge();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_ctrl.md
# bus_ctrl

Bus-cycle controller and priority interrupt arbiter for the i8080 system bus. It snoops the status word the CPU places on the data bus during `sync` and decodes it into memory, I/O and interrupt-acknowledge strobes. It inserts a programmable number of wait states through `ready`. It also arbitrates up to `NUM_IRQ` edge-triggered interrupt requesters and, on INTA, drives the RST opcode of the winner. It sits between `i8080` and the RAM and peripherals, and replaces the ad-hoc status register and glue decode.

## Interface
- `XLEN`, 8, data width; the status and opcode encodings require 8.
- `NUM_IRQ`, 8, number of requesters, 1..8; index 0 has the highest priority.
- `WAIT_STATES`, 0, `ready`-low cycles inserted per bus cycle, 0..15.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sync`  in  1  CPU status strobe; status is valid on `data_in` in this cycle.
- `dbin`  in  1  CPU read strobe.
- `write_n`  in  1  CPU write strobe, active low.
- `data_in`  in  XLEN  data bus snoop.
- `inte`  in  1  CPU interrupt-enable flag.
- `irq`  in  NUM_IRQ  interrupt request lines, rising-edge sensitive.
- `ready`  out  1  to CPU `ready`.
- `int_req`  out  1  to CPU `iint`.
- `mem_enable`  out  1  current cycle is a memory cycle.
- `io_rd`  out  1  I/O read strobe.
- `io_wr`  out  1  I/O write strobe.
- `inta_drive`  out  1  tri-state enable for `inta_data` onto the data bus.
- `inta_data`  out  XLEN  RST opcode, `8'hC7 | (idx << 3)`.
- `irq_ack`  out  NUM_IRQ  one-hot, single-cycle acknowledge pulse.
- `halted`  out  1  CPU is in the HLTA state.

## Operation
- Status latch: `data_in` is captured on a `sync` cycle.
- Status bit meanings: D0 INTA, D1 WO_n, D2 STACK, D3 HLTA, D4 OUT, D5 M1, D6 INP, D7 MEMR.
- Decode from the latched status:
  - `mem_enable` = ~INTA & ~INP & ~OUT.
  - `io_rd` = INP & `dbin`.
  - `io_wr` = OUT & ~`write_n`.
  - `inta_drive` = INTA & `dbin`.
  - `halted` = HLTA.
- Cycle FSM states:
  - IDLE: waiting for `sync`.
  - WAIT: counter running.
  - ACTIVE: `ready`=1, data phase.
- FSM transitions:
  - `sync` in any state → latch status, load counter with WAIT_STATES, go to WAIT. If WAIT_STATES=0, go to ACTIVE directly.
  - WAIT: decrement the counter; at 1 go to ACTIVE.
  - ACTIVE → IDLE on the cycle after the last `dbin`/~`write_n`-high cycle, or on the next `sync`.
- Pending register:
  - Bit i is set on a 0→1 transition of `irq[i]`; `irq` is sampled one flop deep.
  - Bit i is cleared on acknowledge.
  - If set and clear land on the same bit in the same cycle, set wins.
- `int_req` = `inte` & |pending; it is registered.
- Winner selection: the lowest set pending index, frozen into `sel_idx` at the `sync` of an INTA cycle (INTA & M1). Later arrivals do not change the opcode mid-cycle.
- `inta_data` = `8'hC7 | (sel_idx << 3)`; it is held for the whole INTA cycle.
- End of the INTA data phase (falling edge of `dbin`):
  - Clear `pending[sel_idx]`.
  - Pulse `irq_ack[sel_idx]` for exactly 1 cycle.
- INTA with nothing pending (spurious): drive `8'hFF` (RST 7), with no ack and no pending change.
- `halted` clears on the next `sync` of a non-HLTA cycle.

## Timing
- Reset values (async, while `rst_n`=0):
  - FSM = IDLE, status = 0, pending = 0, `sel_idx` = 0, counter = 0.
  - `ready`=1, `int_req`=0, all strobes 0, `irq_ack`=0, `inta_data`=`8'hC7`, `halted`=0.
- Releasing reset mid-cycle abandons the cycle; no ack is issued.
- `ready` falls in the cycle after `sync` and stays low for exactly WAIT_STATES cycles. The decode outputs are valid from the cycle after `sync`.
- `int_req` latency: 2 cycles from `irq` rising, given `inte`=1. It drops 1 cycle after the ack clears the last pending bit.
- `irq` held high does not re-pend; only a new edge does.

## Test plan
- Reset with `rst_n`=0 mid-cycle while `irq`=`8'h01` was pending → all outputs at reset values; after release, `int_req` stays 0 until a new edge.
- Memory read, status `8'hA2`, WAIT_STATES=2 → `ready` low for exactly 2 cycles after `sync`; `mem_enable`=1, `io_rd`=0.
- OUT cycle, status `8'h10`, `write_n` low → `io_wr`=1 for exactly the `write_n`-low cycles; `mem_enable`=0.
- `irq[5]` and `irq[2]` rise together, `inte`=1, then INTA cycle status `8'h23` → `inta_data`=`8'hD7` with `inta_drive` during `dbin`; `irq_ack`=`8'h04` for 1 cycle; `int_req` remains 1. A second INTA → `8'hEF`, ack `8'h20`, then `int_req`=0.
- `irq[0]` edge arrives after the INTA `sync` that selected index 3 → opcode stays `8'hDF`; bit 0 stays pending and wins the next INTA.
- Spurious INTA with pending=0 → `inta_data`=`8'hFF`, `irq_ack`=0. `irq[1]` re-edges in the same cycle its ack clears it → bit stays pending.
